// File: rtl/conv2d_stream_engine.sv
// Valid-mode 2-D convolution: loads a KxK kernel, then MACs one output pixel at a time over the image SRAM.
// Latency: first result 2*(K*K+1) cycles after start; K*K+2 cycles between results when not stalled.
// Backpressure: a result is held on o_valid until i_ready; the engine and SRAM addresses freeze while stalled.
module conv2d_stream_engine #(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int ADDR_WIDTH  = 6,
  parameter int KADDR_WIDTH = 4,
  parameter int ACC_WIDTH   = 24,
  parameter int SHIFT       = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  output logic                   o_busy,
  output logic [KADDR_WIDTH-1:0] o_kernel_addr,
  input  logic [DATA_WIDTH-1:0]  i_kernel_data,
  output logic [ADDR_WIDTH-1:0]  o_img_addr,
  input  logic [DATA_WIDTH-1:0]  i_img_data,
  output logic [DATA_WIDTH-1:0]  o_result,
  output logic [ADDR_WIDTH-1:0]  o_row,
  output logic [ADDR_WIDTH-1:0]  o_col,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_done
);

  localparam int KK = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CW = KADDR_WIDTH + 1;
  localparam logic [CW-1:0]         KK_C       = CW'(KK);
  localparam logic [CW-1:0]         KKM1_C     = CW'(KK - 1);
  localparam logic [ADDR_WIDTH-1:0] KM1_C      = ADDR_WIDTH'(KERNEL_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] IMG_W_C    = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] COL_LAST_C = ADDR_WIDTH'(IMG_W - KERNEL_SIZE);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST_C = ADDR_WIDTH'(IMG_H - KERNEL_SIZE);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX_C = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN_C = ~SAT_MAX_C;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_KERNEL, S_MAC, S_OUTPUT, S_DONE} state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]         kx_q, kx_d, ky_q, ky_d;
  logic [ADDR_WIDTH-1:0]         row_q, row_d, col_q, col_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0]         result_q, result_d;
  logic signed [DATA_WIDTH-1:0]  kernel_q [2**KADDR_WIDTH];
  logic                          kernel_we;

  // Memory data arriving this cycle belongs to the address issued one cycle earlier (cnt - 1).
  logic [KADDR_WIDTH-1:0]        tap_idx;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]   acc_sum;
  logic signed [ACC_WIDTH-1:0]   acc_shift;
  logic [DATA_WIDTH-1:0]         sat_res;

  assign tap_idx   = KADDR_WIDTH'(cnt_q - CW'(1));
  assign prod      = $signed(i_img_data) * kernel_q[tap_idx];
  assign acc_sum   = acc_q + ACC_WIDTH'(prod);
  assign acc_shift = acc_sum >>> SHIFT;

  // Clamp the scaled accumulator into the signed result range.
  always_comb begin
    sat_res = acc_shift[DATA_WIDTH-1:0];
    if (acc_shift > SAT_MAX_C) begin
      sat_res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (acc_shift < SAT_MIN_C) begin
      sat_res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end

  // Next-state and datapath control for the load/MAC/output sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kx_d      = kx_q;
    ky_d      = ky_q;
    row_d     = row_q;
    col_d     = col_q;
    acc_d     = acc_q;
    result_d  = result_q;
    kernel_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_LOAD_KERNEL;
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_LOAD_KERNEL: begin
        cnt_d     = cnt_q + CW'(1);
        kernel_we = (cnt_q != '0);
        if (cnt_q == KK_C) begin
          state_d = S_MAC;
          cnt_d   = '0;
          kx_d    = '0;
          ky_d    = '0;
          acc_d   = '0;
        end
      end
      S_MAC: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q != '0) acc_d = acc_sum;
        // The last tap address simply stays on the bus through the final accumulate and OUTPUT.
        if (cnt_q < KKM1_C) begin
          if (kx_q == KM1_C) begin
            kx_d = '0;
            ky_d = ky_q + ADDR_WIDTH'(1);
          end else begin
            kx_d = kx_q + ADDR_WIDTH'(1);
          end
        end
        if (cnt_q == KK_C) begin
          result_d = sat_res;
          state_d  = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (i_ready) begin
          if (row_q == ROW_LAST_C && col_q == COL_LAST_C) begin
            state_d = S_DONE;
          end else begin
            if (col_q == COL_LAST_C) begin
              col_d = '0;
              row_d = row_q + ADDR_WIDTH'(1);
            end else begin
              col_d = col_q + ADDR_WIDTH'(1);
            end
            state_d = S_MAC;
            cnt_d   = '0;
            kx_d    = '0;
            ky_d    = '0;
            acc_d   = '0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any run in progress.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Counters, window position, accumulator and held result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q    <= '0;
      kx_q     <= '0;
      ky_q     <= '0;
      row_q    <= '0;
      col_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      kx_q     <= kx_d;
      ky_q     <= ky_d;
      row_q    <= row_d;
      col_q    <= col_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // Kernel register file, filled one word per cycle during the load phase.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 2**KADDR_WIDTH; i++) kernel_q[i] <= '0;
    end else if (kernel_we) begin
      kernel_q[tap_idx] <= i_kernel_data;
    end
  end

  assign o_kernel_addr = (state_q == S_LOAD_KERNEL && cnt_q < KK_C) ? KADDR_WIDTH'(cnt_q) : '0;
  assign o_img_addr    = (row_q + ky_q) * IMG_W_C + col_q + kx_q;
  assign o_result      = result_q;
  assign o_row         = row_q;
  assign o_col         = col_q;
  assign o_valid       = (state_q == S_OUTPUT);
  assign o_done        = (state_q == S_DONE);
  assign o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Bench for conv2d_stream_engine: default geometry plus a SHIFT=4 twin run in lockstep on the same memories.
// Each job is driven from a vector table; expected pixels are queued at start and popped on every transfer.
// Hand-written sequences cover the start timing, stalls, ignored restarts and an asynchronous abort.
module tb_conv2d_stream_engine;

  logic       i_clk;
  logic       i_rst;
  logic       i_start;
  logic       i_ready;
  logic [7:0] kdat;
  logic [7:0] idat;

  logic       o_busy, o_valid, o_done;
  logic [3:0] o_kernel_addr;
  logic [5:0] o_img_addr, o_row, o_col;
  logic [7:0] o_result;

  logic       busy4, valid4, done4;
  logic [3:0] kaddr4;
  logic [5:0] iaddr4, row4, col4;
  logic [7:0] result4;

  conv2d_stream_engine u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .o_busy(o_busy),
    .o_kernel_addr(o_kernel_addr), .i_kernel_data(kdat),
    .o_img_addr(o_img_addr), .i_img_data(idat),
    .o_result(o_result), .o_row(o_row), .o_col(o_col),
    .o_valid(o_valid), .i_ready(i_ready), .o_done(o_done)
  );

  conv2d_stream_engine #(.SHIFT(4)) u_dut_s4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .o_busy(busy4),
    .o_kernel_addr(kaddr4), .i_kernel_data(kdat),
    .o_img_addr(iaddr4), .i_img_data(idat),
    .o_result(result4), .o_row(row4), .o_col(col4),
    .o_valid(valid4), .i_ready(i_ready), .o_done(done4)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic signed [7:0] img_mem [64];
  logic signed [7:0] ker_mem [16];

  // One-cycle synchronous-read memories.
  always @(posedge i_clk) begin
    kdat <= ker_mem[o_kernel_addr];
    idat <= img_mem[o_img_addr];
  end

  typedef struct {
    int row;
    int col;
    int res;
    int res4;
  } exp_t;

  typedef struct {
    int img_mode;
    int ker_mode;
    int ready_mode;
    int start_mid;
    int exp_first;
    int exp_first4;
    int exp_last;
    int exp_last4;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int model(input int r, input int c, input int sh);
    int acc;
    acc = 0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        acc += int'(img_mem[(r + ky) * 8 + c + kx]) * int'(ker_mem[ky * 3 + kx]);
    acc = acc >>> sh;
    if (acc > 127) acc = 127;
    if (acc < -128) acc = -128;
    return acc;
  endfunction

  task automatic load_mem(input int img_mode, input int ker_mode);
    for (int i = 0; i < 64; i++) begin
      case (img_mode)
        0: img_mem[i] = 8'sd1;
        1: img_mem[i] = 8'(8 * (i / 8) + (i % 8));
        2: img_mem[i] = 8'sd127;
        default: img_mem[i] = 8'($urandom_range(0, 255));
      endcase
    end
    for (int i = 0; i < 16; i++) ker_mem[i] = 8'sd0;
    for (int i = 0; i < 9; i++) begin
      case (ker_mode)
        0: ker_mem[i] = 8'sd1;
        1: ker_mem[i] = (i == 4) ? 8'sd1 : 8'sd0;
        2: ker_mem[i] = 8'sd127;
        3: ker_mem[i] = 8'(-128);
        default: ker_mem[i] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  // Runs one full job starting at a negedge; ready_mode 0=always, 1=stall 5 at first valid, 2=random.
  task automatic run_job(input int ready_mode, input int start_mid,
                         input int exp_first, input int exp_first4,
                         input int exp_last, input int exp_last4);
    int   first_rise, prev_rise, ndone, last_xfer_m, done_m, stall, nxfer, ea;
    bit   prev_valid, prev_hold, prev_xfer, finished;
    logic [7:0] h_res;
    logic [5:0] h_row, h_col, h_addr;
    exp_t e;
    first_rise = -1; prev_rise = -1; ndone = 0; last_xfer_m = -1; done_m = -1;
    stall = 0; nxfer = 0; prev_valid = 0; prev_hold = 0; prev_xfer = 0; finished = 0;
    h_res = '0; h_row = '0; h_col = '0; h_addr = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        sb.push_back('{r, c, model(r, c, 0), model(r, c, 4)});
    i_start = 1'b1;
    for (int m = 0; m < 3000 && !finished; m++) begin
      @(negedge i_clk);
      i_start = (start_mid != 0 && m == 50);
      if (m == 0) begin
        check("busy_after_start", int'(o_busy), 1);
        check("kernel_addr_first", int'(o_kernel_addr), 0);
      end
      if (prev_hold)
        check("stall_hold", int'({o_valid, o_result, o_row, o_col, o_img_addr}),
              int'({1'b1, h_res, h_row, h_col, h_addr}));
      if (prev_xfer) check("valid_drop_after_xfer", int'(o_valid), 0);
      if (o_valid && !prev_valid) begin
        if (first_rise < 0) begin
          first_rise = m;
          check("first_valid_cycle", m, 20);
        end else if (ready_mode == 0) begin
          check("valid_spacing", m - prev_rise, 11);
        end
        prev_rise = m;
      end
      if (o_done) begin
        ndone++;
        if (ndone == 1) begin
          check("done_after_last_xfer", m, last_xfer_m + 1);
          done_m = m;
        end
      end
      if (done_m >= 0 && m == done_m + 1) begin
        check("done_one_cycle", int'(o_done), 0);
        check("busy_after_done", int'(o_busy), 0);
        finished = 1;
      end
      case (ready_mode)
        0: i_ready = 1'b1;
        1: begin
          if (o_valid && nxfer == 0 && stall < 5) begin
            i_ready = 1'b0;
            stall++;
          end else begin
            i_ready = 1'b1;
          end
        end
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
      prev_xfer = o_valid && i_ready;
      prev_hold = o_valid && !i_ready;
      h_res = o_result; h_row = o_row; h_col = o_col; h_addr = o_img_addr;
      if (prev_xfer) begin
        last_xfer_m = m;
        nxfer++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_output: got pixel (%0d,%0d), expected none", o_row, o_col);
        end else begin
          e = sb.pop_front();
          ea = (e.row + 2) * 8 + e.col + 2;
          check("out_row", int'(o_row), e.row);
          check("out_col", int'(o_col), e.col);
          check("out_result", int'($signed(o_result)), e.res);
          check("out_result_shift4", int'($signed(result4)), e.res4);
          check("img_addr_in_output", int'(o_img_addr), ea);
          check("shift4_lockstep", int'({valid4, busy4, done4, row4, col4, kaddr4, iaddr4}),
                int'({1'b1, 1'b1, 1'b0, 6'(e.row), 6'(e.col), 4'd0, 6'(ea)}));
          if (nxfer == 1 && exp_first != -1000) begin
            check("table_first", int'($signed(o_result)), exp_first);
            check("table_first_shift4", int'($signed(result4)), exp_first4);
          end
          if (e.row == 5 && e.col == 5 && exp_last != -1000) begin
            check("table_last", int'($signed(o_result)), exp_last);
            check("table_last_shift4", int'($signed(result4)), exp_last4);
          end
        end
      end
      prev_valid = o_valid;
    end
    check("job_finished", int'(finished), 1);
    check("done_pulses", ndone, 1);
    check("all_outputs_seen", sb.size(), 0);
    sb.delete();
    i_ready = 1'b0;
    i_start = 1'b0;
  endtask

  vec_t vecs [5];

  initial begin
    bit found;
    i_rst = 1'b0; i_start = 1'b0; i_ready = 1'b0;
    #1 i_rst = 1'b1;
    #1;
    check("rst_busy", int'(o_busy), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_result", int'(o_result), 0);
    check("rst_row_col", int'({o_row, o_col}), 0);
    check("rst_addrs", int'({o_kernel_addr, o_img_addr}), 0);
    @(negedge i_clk);
    i_rst = 1'b0;

    vecs[0] = '{0, 0, 0, 0,     9,     0,     9,     0};
    vecs[1] = '{1, 1, 0, 1,     9,     0,    54,     3};
    vecs[2] = '{2, 2, 1, 0,   127,   127,   127,   127};
    vecs[3] = '{2, 3, 0, 0,  -128,  -128,  -128,  -128};
    vecs[4] = '{3, 4, 2, 1, -1000, -1000, -1000, -1000};

    for (int v = 0; v < 5; v++) begin
      load_mem(vecs[v].img_mode, vecs[v].ker_mode);
      run_job(vecs[v].ready_mode, vecs[v].start_mid,
              vecs[v].exp_first, vecs[v].exp_first4, vecs[v].exp_last, vecs[v].exp_last4);
      repeat (2) @(negedge i_clk);
    end

    // Abort mid-MAC on pixel (2,3), then confirm a fresh run is complete and correct.
    load_mem(1, 1);
    found = 0;
    i_ready = 1'b1;
    i_start = 1'b1;
    for (int m = 0; m < 1000 && !found; m++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      if (o_busy && !o_valid && o_row == 6'd2 && o_col == 6'd3) found = 1;
    end
    check("reach_pixel_2_3", int'(found), 1);
    repeat (3) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    check("abort_valid", int'(o_valid), 0);
    check("abort_busy", int'(o_busy), 0);
    check("abort_result", int'(o_result), 0);
    check("abort_result_shift4", int'(result4), 0);
    check("abort_row_col", int'({o_row, o_col}), 0);
    check("abort_addrs", int'({o_kernel_addr, o_img_addr}), 0);
    check("abort_done", int'(o_done), 0);
    i_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    check("idle_after_abort", int'({o_busy, o_valid}), 0);
    run_job(0, 0, 9, 0, 54, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv2d_stream_engine.md
# conv2d_stream_engine

Parametrised 2-D convolution engine for the NPU datapath. It loads a KERNEL_SIZE×KERNEL_SIZE signed kernel from kernel memory, then sweeps a valid-mode (no padding) window across an IMG_W×IMG_H image held in synchronous-read SRAM. Each output pixel is produced by a sequential multiply-accumulate with shift and saturation, and results are delivered on a valid/ready stream in raster order. It generalises the earlier single-window convolver with arbitrary image geometry, accumulator sizing, output scaling and back-pressure.

## Interface
- KERNEL_SIZE, 3: kernel edge K; K ≥ 1, K ≤ IMG_W, K ≤ IMG_H
- DATA_WIDTH, 8: signed pixel, kernel and result width
- IMG_W, 8: image width in pixels
- IMG_H, 8: image height in pixels
- ADDR_WIDTH, 6: image SRAM address width; must satisfy 2^ADDR_WIDTH ≥ IMG_W·IMG_H
- KADDR_WIDTH, 4: kernel address width; must satisfy 2^KADDR_WIDTH ≥ K·K
- ACC_WIDTH, 24: signed accumulator width; must satisfy ≥ 2·DATA_WIDTH + ceil(log2(K·K))
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation

Ports:
- i_clk  in  1  clock; all logic is rising-edge
- i_rst  in  1  reset; asynchronous, active-high
- i_start  in  1  start request; sampled only in IDLE
- o_busy  out  1  high in every state except IDLE
- o_kernel_addr  out  KADDR_WIDTH  kernel memory read address
- i_kernel_data  in  DATA_WIDTH  signed kernel word; valid 1 cycle after its address
- o_img_addr  out  ADDR_WIDTH  image SRAM read address, row-major (y·IMG_W+x)
- i_img_data  in  DATA_WIDTH  signed pixel; valid 1 cycle after its address
- o_result  out  DATA_WIDTH  signed saturated output pixel
- o_row  out  ADDR_WIDTH  output row index of o_result
- o_col  out  ADDR_WIDTH  output column index of o_result
- o_valid  out  1  o_result, o_row and o_col are valid
- i_ready  in  1  downstream accepts; a transfer occurs when o_valid && i_ready
- o_done  out  1  one-cycle pulse after the final transfer

## Operation
- States: IDLE, LOAD_KERNEL, MAC, OUTPUT, DONE.
- IDLE: when i_start=1, clear the row/col counters and go to LOAD_KERNEL.
- LOAD_KERNEL (K·K+1 cycles):
  - Present addresses 0..K·K-1 on consecutive cycles.
  - Store the word returned for address n into kernel[n] one cycle later.
  - After the last store, go to MAC.
- MAC (K·K+1 cycles per output pixel):
  - Clear the accumulator on entry.
  - Tap t = ky·K+kx presents o_img_addr = (row+ky)·IMG_W + (col+kx).
  - One cycle later, acc += i_img_data × kernel[t], signed, full 2·DATA_WIDTH product sign-extended to ACC_WIDTH.
  - After the last tap accumulates, latch o_result and go to OUTPUT.
- Result arithmetic:
  - s = acc >>> SHIFT.
  - Clamp s to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- OUTPUT:
  - Hold o_valid=1; o_result, o_row and o_col stay stable until a transfer.
  - On transfer, advance col. When col wraps at IMG_W-K, set col=0 and row++.
  - If the transfer was for the last pixel (row=IMG_H-K, col=IMG_W-K), go to DONE; otherwise go to MAC.
- DONE: assert o_done for exactly one cycle, then go to IDLE.
- Output count is (IMG_W-K+1)·(IMG_H-K+1), in raster order.
- Boundary rules:
  - i_start while busy is ignored; it does not queue.
  - i_ready low stalls in OUTPUT indefinitely; SRAM addresses hold.
  - i_ready high before o_valid has no effect.
  - K = IMG_W = IMG_H produces a single output.
  - i_rst at any time, including mid-MAC or mid-OUTPUT, aborts the run immediately; the next run requires a new i_start.
  - No interrupted result is ever emitted.

## Timing
- Reset values: state=IDLE; o_busy, o_valid, o_done, o_result, o_row, o_col, o_kernel_addr, o_img_addr all 0. The accumulator and kernel registers are also cleared.
- i_start high at edge E0:
  - o_busy is high after E0.
  - o_kernel_addr=0 during the first cycle after E0.
  - The first o_valid rises after edge E0 + 2·(K·K+1). For K=3 this is 20 cycles.
- With i_ready held high, successive outputs are K·K+2 cycles apart.
- o_done rises the cycle after the final transfer; o_busy falls one cycle after o_done.
- Memories are assumed to have exactly 1-cycle synchronous read latency; no other wait states are supported.

## Test plan
- K=3, 8×8 image all 1, kernel all 1, i_ready=1 -> 36 outputs, each 9; rows/cols run (0,0)..(5,5); o_done pulses once.
- Identity kernel (center 1, others 0), image pixel(y,x)=8y+x -> output(r,c)=8(r+1)+c+1; first value 9, last 54.
- Saturation: image all 127, kernel all 127 -> every output 127; kernel all -128 -> every output -128. SHIFT=4 with all-1 image and all-1 kernel -> 0.
- Back-pressure: i_ready low for 5 cycles at the first o_valid -> o_valid, o_result and o_img_addr are stable; the transfer happens on the first i_ready=1 cycle.
- Cycle count: first o_valid exactly 20 cycles after the i_start edge; then 11-cycle spacing. i_start pulsed mid-run is ignored and produces no extra outputs.
- Reset mid-MAC on pixel (2,3) -> all outputs 0 asynchronously, before the next edge. A subsequent restart reproduces the full, correct 36-result sequence.
